// File: rtl/popcount_pkg.sv
// Shared types and helpers for the popcount stimulus expander family.
package popcount_pkg;

  localparam int WIDTH_DEF  = 12;
  localparam int THERMO_MAX = 256;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  function automatic int cw_f(input int width);
    return $clog2(width + 1);
  endfunction

  // Counts above width saturate to an all-ones code of that width.
  function automatic logic [THERMO_MAX-1:0] thermo(input int unsigned k, input int unsigned width);
    logic [THERMO_MAX-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < THERMO_MAX; i++) begin
      if (i < k && i < width) t[i] = 1'b1;
    end
    return t;
  endfunction

endpackage

// File: rtl/popcount_thermo_rot.sv
// Combinational rotl(thermo(k), rot); rot must be below WIDTH.
module popcount_thermo_rot
  import popcount_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = cw_f(WIDTH),
  parameter int RW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [CW-1:0]    k_i,
  input  logic [RW-1:0]    rot_i,
  output logic [WIDTH-1:0] vec_o
);

  logic [WIDTH-1:0] therm;

  assign therm = WIDTH'(thermo(32'(k_i), WIDTH));
  // Shift by WIDTH when rot is zero yields zero, so no special case is needed.
  assign vec_o = (therm << rot_i) | (therm >> (WIDTH - int'(rot_i)));

endmodule

// File: rtl/popcount_unary_expander.sv
// Expands an accepted count k into BEATS rotating thermometer vectors with popcount k.
// Beat 0 is registered at the accepting edge; all outputs hold while out_ready is low.
module popcount_unary_expander
  import popcount_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = cw_f(WIDTH),
  parameter int BEATS = 12,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_vec,
  output logic [CW-1:0]    out_count,
  output logic             out_last,
  output logic             out_sat,
  output logic             busy
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    k_q, k_d;
  logic             sat_q, sat_d;
  logic [RW-1:0]    rot_q, rot_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [WIDTH-1:0] vec_q, vec_d, vec_rot;
  logic             last_q, last_d;
  logic             out_fire, in_fire;
  logic [RW:0]      rot_sum;

  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q == EMIT);
  assign out_vec   = vec_q;
  assign out_count = k_q;
  assign out_last  = last_q;
  assign out_sat   = sat_q;

  assign out_fire = out_valid && out_ready;
  // Only open mid-EMIT on the final handshake, which makes back-to-back bursts bubble-free.
  assign in_ready = rst_n && ((state_q == IDLE) || (out_fire && last_q));
  assign in_fire  = in_valid && in_ready;
  assign rot_sum  = {1'b0, rot_q} + (RW+1)'(STEP);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    sat_d   = sat_q;
    rot_d   = rot_q;
    beat_d  = beat_q;
    if (in_fire) begin
      state_d = EMIT;
      sat_d   = (in_count > CW'(WIDTH));
      k_d     = sat_d ? CW'(WIDTH) : in_count;
      rot_d   = '0;
      beat_d  = '0;
    end else if (out_fire) begin
      if (last_q) begin
        state_d = IDLE;
      end else begin
        beat_d = beat_q + BW'(1);
        rot_d  = (rot_sum >= (RW+1)'(WIDTH)) ? RW'(rot_sum - (RW+1)'(WIDTH)) : rot_sum[RW-1:0];
      end
    end
    last_d = (state_d == EMIT) && (beat_d == BW'(BEATS - 1));
    vec_d  = (state_d == EMIT) ? vec_rot : '0;
  end

  popcount_thermo_rot #(
    .WIDTH (WIDTH),
    .CW    (CW),
    .RW    (RW)
  ) u_thermo_rot (
    .k_i   (k_d),
    .rot_i (rot_d),
    .vec_o (vec_rot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      sat_q   <= 1'b0;
      rot_q   <= '0;
      beat_q  <= '0;
      vec_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      sat_q   <= sat_d;
      rot_q   <= rot_d;
      beat_q  <= beat_d;
      vec_q   <= vec_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_popcount_unary_expander.sv
// Directed and scoreboarded checks for popcount_unary_expander at WIDTH=12, BEATS=12, STEP=1.
module tb_popcount_unary_expander;

  localparam int WIDTH = 12;
  localparam int CW    = 4;
  localparam int BEATS = 12;
  localparam int NRAND = 20;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [CW-1:0]    in_count;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_vec;
  logic [CW-1:0]    out_count;
  logic             out_last;
  logic             out_sat;
  logic             busy;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] t5 [12] = '{12'h01F, 12'h03E, 12'h07C, 12'h0F8, 12'h1F0, 12'h3E0,
                                12'h7C0, 12'hF80, 12'hF01, 12'hE03, 12'hC07, 12'h80F};

  always #5 clk = ~clk;

  popcount_unary_expander #(
    .WIDTH (WIDTH),
    .CW    (CW),
    .BEATS (BEATS),
    .STEP  (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_count  (in_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_count (out_count),
    .out_last  (out_last),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int clampc(input int c);
    return (c > WIDTH) ? WIDTH : c;
  endfunction

  function automatic logic [WIDTH-1:0] model_vec(input int c, input int rot);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < clampc(c); i++) v[(i + rot) % WIDTH] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int c);
    in_valid = 1'b1;
    in_count = CW'(c);
    #1;
    check("accept_rdy", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // Expects beat 0 of count c to be presented; optionally offers the next count throughout.
  task automatic burst(input int c, input bit nxt, input int nc);
    for (int b = 0; b < BEATS; b++) begin
      in_valid = nxt;
      in_count = CW'(nc);
      #1;
      check("b_valid", out_valid, 1);
      check("b_busy", busy, 1);
      check("b_vec", out_vec, model_vec(c, b % WIDTH));
      check("b_count", out_count, clampc(c));
      check("b_sat", out_sat, (c > WIDTH));
      check("b_last", out_last, (b == BEATS - 1));
      check("b_inrdy", in_ready, (b == BEATS - 1));
      tick();
    end
  endtask

  initial begin
    int q[$];
    int sent, beats_tot, bcnt, cur, cyc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_count  = '0;
    out_ready = 1'b1;
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_inrdy", in_ready, 0);
    check("rst_vec", out_vec, 0);
    check("rst_count", out_count, 0);
    check("rst_last", out_last, 0);
    check("rst_sat", out_sat, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("idle_inrdy", in_ready, 1);
    tick();

    // count 5 against a hand table
    start(5);
    for (int b = 0; b < BEATS; b++) begin
      #1;
      check("k5_vec", out_vec, t5[b]);
      check("k5_count", out_count, 5);
      check("k5_sat", out_sat, 0);
      check("k5_last", out_last, (b == BEATS - 1));
      tick();
    end
    check("k5_idle", out_valid, 0);

    // count 0 then 12 with no bubble
    start(0);
    burst(0, 1'b1, 12);
    in_valid = 1'b0;
    burst(12, 1'b0, 0);
    check("b2b_idle", out_valid, 0);

    // saturation
    start(15);
    burst(15, 1'b0, 0);
    check("sat_idle", out_valid, 0);

    // backpressure at beat 2
    start(3);
    tick();
    tick();
    out_ready = 1'b0;
    repeat (3) begin
      #1;
      check("stall_vec", out_vec, 12'h01C);
      check("stall_last", out_last, 0);
      check("stall_valid", out_valid, 1);
      check("stall_inrdy", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("stall_hold", out_vec, 12'h01C);
    tick();
    check("stall_next", out_vec, 12'h038);
    repeat (BEATS - 3) tick();
    check("stall_idle", out_valid, 0);

    // reset mid-burst
    start(7);
    repeat (4) tick();
    check("pre_rst_vec", out_vec, 12'h7F0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_inrdy", in_ready, 0);
    check("mid_rst_vec", out_vec, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check("post_rst_inrdy", in_ready, 1);
    check("post_rst_valid", out_valid, 0);
    start(1);
    burst(1, 1'b0, 0);

    // random counts with random backpressure
    sent = 0; beats_tot = 0; bcnt = 0; cur = 0; cyc = 0;
    while (cyc < 4000 && !(sent == NRAND && q.size() == 0 && bcnt == 0 && !out_valid)) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (sent < NRAND) && ($urandom_range(0, 1) == 1);
      in_count  = CW'($urandom_range(0, 15));
      #1;
      if (out_valid && out_ready) begin
        if (bcnt == 0) begin
          check("rand_queue", (q.size() > 0), 1);
          if (q.size() > 0) cur = q.pop_front();
        end
        check("rand_pop", $countones(out_vec), clampc(cur));
        check("rand_cnt", out_count, clampc(cur));
        bcnt++;
        beats_tot++;
        if (out_last) begin
          check("rand_len", bcnt, BEATS);
          bcnt = 0;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(int'(in_count));
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("rand_done", (cyc < 4000), 1);
    check("rand_beats", beats_tot, NRAND * BEATS);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
